axis_pattern_gen: RTL and testbench



---
 rtl/axis_pattern_gen.sv | 202 ++++++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen.sv
// AXI-Stream frame source producing deterministic, self-describing frames with gaps and run control.
// Optional bad-frame marking on tuser is enabled by defining AXIS_PATTERN_GEN_BAD_FRAME_EN.
module axis_pattern_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned GAP_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_count,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [7:0]            cfg_seed,
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
    input  logic [7:0]            cfg_bad_every,
`endif
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t state, state_d;

    logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d, fidx_q, fidx_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
    logic [7:0]            seed_q, seed_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [31:0]           frames_d;
    logic [DATA_WIDTH-1:0] tdata_d;
    logic                  tvalid_d, tlast_d, tuser_d, busy_d, done_d;
    logic [7:0]            lane_base;

`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
    logic [7:0] bad_every_q, bad_every_d, bad_cnt_q, bad_cnt_d;
`endif

    logic hs, last_beat, run_done, stop_any;

    assign hs        = m_axis_tvalid && m_axis_tready;
    assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
    assign run_done  = (count_q != '0) && (fidx_q + CNT_WIDTH'(1) == count_q);
    assign stop_any  = stop_pend_q || stop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (start) state_d = ST_SEND;
            ST_SEND: begin
                if (hs && last_beat) begin
                    if (run_done || stop_any) state_d = ST_IDLE;
                    else if (gap_q == '0)     state_d = ST_SEND;
                    else                      state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop_any)                       state_d = ST_IDLE;
                else if (gcnt_q <= GAP_WIDTH'(1))   state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter updates and next values of the registered outputs, derived from the upcoming state
    always_comb begin
        len_d       = len_q;
        count_d     = count_q;
        gap_d       = gap_q;
        seed_d      = seed_q;
        beat_d      = beat_q;
        fidx_d      = fidx_q;
        gcnt_d      = gcnt_q;
        frames_d    = frames_sent;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q || ((state != ST_IDLE) && stop);
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
        bad_every_d = bad_every_q;
        bad_cnt_d   = bad_cnt_q;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_d   = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
                    count_d = cfg_frame_count;
                    gap_d   = cfg_gap;
                    seed_d  = cfg_seed;
                    beat_d  = '0;
                    fidx_d  = '0;
                    gcnt_d  = '0;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
                    bad_every_d = cfg_bad_every;
                    bad_cnt_d   = 8'd1;
`endif
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (last_beat) begin
                        beat_d   = '0;
                        fidx_d   = fidx_q + CNT_WIDTH'(1);
                        frames_d = frames_sent + 32'd1;
                        done_d   = run_done;
                        gcnt_d   = gap_q;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
                        bad_cnt_d = (bad_cnt_q == bad_every_q) ? 8'd1 : bad_cnt_q + 8'd1;
`endif
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_GAP:  gcnt_d = gcnt_q - GAP_WIDTH'(1);
            default: ;
        endcase
        if (state_d == ST_IDLE) stop_pend_d = 1'b0;

        tvalid_d  = (state_d == ST_SEND);
        busy_d    = (state_d != ST_IDLE);
        tdata_d   = '0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        lane_base = seed_d + fidx_d[7:0] + 8'(beat_d) * 8'(KEEP_WIDTH);
        if (state_d == ST_SEND) begin
            for (int unsigned i = 0; i < KEEP_WIDTH; i++) tdata_d[i*8 +: 8] = lane_base + 8'(i);
            tlast_d = (beat_d == len_d - LEN_WIDTH'(1));
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
            tuser_d = tlast_d && (bad_every_d != 8'd0) && (bad_cnt_d == bad_every_d);
`endif
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q         <= '0;
            count_q       <= '0;
            gap_q         <= '0;
            seed_q        <= '0;
            beat_q        <= '0;
            fidx_q        <= '0;
            gcnt_q        <= '0;
            stop_pend_q   <= 1'b0;
            frames_sent   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '1;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
            bad_every_q   <= '0;
            bad_cnt_q     <= '0;
`endif
        end else begin
            len_q         <= len_d;
            count_q       <= count_d;
            gap_q         <= gap_d;
            seed_q        <= seed_d;
            beat_q        <= beat_d;
            fidx_q        <= fidx_d;
            gcnt_q        <= gcnt_d;
            stop_pend_q   <= stop_pend_d;
            frames_sent   <= frames_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tkeep  <= '1;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tuser  <= tuser_d;
            busy          <= busy_d;
            done          <= done_d;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
            bad_every_q   <= bad_every_d;
            bad_cnt_q     <= bad_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Testbench for axis_pattern_gen: randomized runs compared against a frame-list reference model.
module tb_axis_pattern_gen;
    localparam int unsigned DW = 16;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned LW = 16;
    localparam int unsigned GW = 8;
    localparam int unsigned CW = 16;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst, start, stop, tready;
    logic [LW-1:0] cfg_frame_len;
    logic [CW-1:0] cfg_frame_count;
    logic [GW-1:0] cfg_gap;
    logic [7:0]    cfg_seed;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
    logic [7:0]    cfg_bad_every;
`endif
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid, tlast, tuser, busy, done;
    logic [31:0]   frames_sent;

    axis_pattern_gen #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
        .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
        .cfg_bad_every(cfg_bad_every),
`endif
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] fs_exp;

    // Per-cycle trace of one run, plus the handshaked beats extracted from it
    bit            tr_valid[$], tr_ready[$], tr_last[$], tr_done[$], tr_busy[$];
    logic [DW-1:0] tr_data[$];
    logic [DW-1:0] h_data[$];
    bit            h_last[$], h_user[$];
    int            h_idx[$];
    bit            timed_out;
    int            n_done, done_at, fall_at, last_hs, idle_valid;

    // Expected beats from the reference model
    logic [DW-1:0] e_data[$];
    bit            e_last[$], e_user[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input int cnt, input int gap, input int seed, input int be);
        cfg_frame_len   = LW'(len);
        cfg_frame_count = CW'(cnt);
        cfg_gap         = GW'(gap);
        cfg_seed        = 8'(seed);
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
        cfg_bad_every   = 8'(be);
`else
        if (be < 0) cfg_seed = 8'(seed);
`endif
        tready = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Runs from the first cycle after start until busy drops, scrambling cfg inputs every cycle
    task automatic run_trace(input int rmode, input int stop_at, input int start_at);
        tr_valid.delete(); tr_ready.delete(); tr_last.delete(); tr_done.delete();
        tr_busy.delete(); tr_data.delete();
        h_data.delete(); h_last.delete(); h_user.delete(); h_idx.delete();
        timed_out = 1'b1;
        for (int t = 0; t < BUDGET; t++) begin
            case (rmode)
                0:       tready = 1'b1;
                1:       tready = (t % 2 == 0);
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
            stop            = (t == stop_at);
            start           = (t == start_at);
            cfg_frame_len   = LW'($urandom_range(0, 9));
            cfg_frame_count = CW'($urandom_range(0, 5));
            cfg_gap         = GW'($urandom_range(0, 5));
            cfg_seed        = 8'($urandom);
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
            cfg_bad_every   = 8'($urandom_range(0, 3));
`endif
            tr_valid.push_back(tvalid); tr_ready.push_back(tready); tr_last.push_back(tlast);
            tr_done.push_back(done); tr_busy.push_back(busy); tr_data.push_back(tdata);
            if (tvalid && tready) begin
                h_data.push_back(tdata); h_last.push_back(tlast);
                h_user.push_back(tuser); h_idx.push_back(t);
            end
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        stop = 1'b0; start = 1'b0; tready = 1'b1;
        n_done = 0; done_at = -1; idle_valid = 0;
        fall_at = tr_busy.size() - 1;
        last_hs = (h_idx.size() > 0) ? h_idx[h_idx.size()-1] : -1;
        for (int t = 0; t < tr_busy.size(); t++) begin
            if (tr_done[t]) begin
                n_done++;
                if (done_at < 0) done_at = t;
            end
            if (tr_busy[t] && !tr_valid[t]) idle_valid++;
        end
    endtask

    // Reference model: frame f, beat b, lane i carries (seed + f + b*KW + i) mod 256
    task automatic build_exp(input int len, input int cnt, input int seed, input int be);
        int l, bev;
        logic [DW-1:0] d;
        e_data.delete(); e_last.delete(); e_user.delete();
        l = (len == 0) ? 1 : len;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
        bev = be;
`else
        bev = (be < 0) ? be : 0;
`endif
        for (int f = 0; f < cnt; f++)
            for (int b = 0; b < l; b++) begin
                d = '0;
                for (int i = 0; i < int'(KW); i++) d[i*8 +: 8] = 8'((seed + f + b * int'(KW) + i) % 256);
                e_data.push_back(d);
                e_last.push_back(b == l - 1);
                e_user.push_back((b == l - 1) && (bev > 0) && ((f + 1) % bev == 0));
            end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1;
        cfg_frame_len = '0; cfg_frame_count = '0; cfg_gap = '0; cfg_seed = '0;
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
        cfg_bad_every = '0;
`endif
        tick(); tick();
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        checks++; if (tlast !== 1'b0 || tuser !== 1'b0) begin errors++; $display("FAIL reset_tlast_tuser: got %b%b expected 00", tlast, tuser); end
        checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
        checks++; if (tkeep !== '1) begin errors++; $display("FAIL reset_tkeep: got %b expected all ones", tkeep); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        checks++; if (frames_sent !== 32'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", frames_sent); end
        rst = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL idle_stop: got busy %b tvalid %b expected 0 0", busy, tvalid); end
        fs_exp = 32'd0;
    endtask

    task automatic test_basic();
        do_start(4, 2, 0, 'h10, 0);
        run_trace(0, -1, -1);
        build_exp(4, 2, 'h10, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: still busy after %0d cycles expected idle", BUDGET); end
        checks++; if (tr_valid[0] !== 1'b1 || tr_busy[0] !== 1'b1) begin errors++; $display("FAIL basic_latency: got tvalid %b busy %b expected 1 1", tr_valid[0], tr_busy[0]); end
        checks++; if (h_data.size() != e_data.size()) begin errors++; $display("FAIL basic_count: got %0d beats expected %0d", h_data.size(), e_data.size()); end
        for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
            checks++;
            if (h_data[k] !== e_data[k] || h_last[k] !== e_last[k] || h_user[k] !== e_user[k] || h_idx[k] != k) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h/%b/%b at %0d expected %h/%b/%b at %0d", k, h_data[k], h_last[k], h_user[k], h_idx[k], e_data[k], e_last[k], e_user[k], k);
            end
        end
        checks++; if (n_done != 1 || done_at != last_hs + 1) begin errors++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", n_done, done_at, last_hs + 1); end
        checks++; if (fall_at != last_hs + 1) begin errors++; $display("FAIL basic_busy_fall: got %0d expected %0d", fall_at, last_hs + 1); end
        fs_exp += 32'd2;
        checks++; if (frames_sent !== fs_exp) begin errors++; $display("FAIL basic_frames: got %0d expected %0d", frames_sent, fs_exp); end
    endtask

    task automatic test_stall();
        do_start(3, 1, 0, $urandom_range(0, 255), 0);
        build_exp(3, 1, int'(cfg_seed), 0);
        run_trace(1, -1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: still busy after %0d cycles expected idle", BUDGET); end
        checks++; if (h_data.size() != 3) begin errors++; $display("FAIL stall_count: got %0d handshakes expected 3", h_data.size()); end
        for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
            checks++;
            if (h_data[k] !== e_data[k] || h_last[k] !== e_last[k]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", k, h_data[k], h_last[k], e_data[k], e_last[k]);
            end
        end
        for (int t = 0; t + 1 < tr_valid.size(); t++) begin
            if (tr_valid[t] && !tr_ready[t]) begin
                checks++;
                if (tr_valid[t+1] !== 1'b1 || tr_data[t+1] !== tr_data[t] || tr_last[t+1] !== tr_last[t]) begin
                    errors++;
                    $display("FAIL stall_hold%0d: got %b/%h/%b expected 1/%h/%b", t, tr_valid[t+1], tr_data[t+1], tr_last[t+1], tr_data[t], tr_last[t]);
                end
            end
        end
        checks++; if (fall_at != last_hs + 1) begin errors++; $display("FAIL stall_busy_fall: got %0d expected %0d", fall_at, last_hs + 1); end
        fs_exp += 32'd1;
    endtask

    task automatic test_gap();
        // stop coinciding with start in IDLE must not cut the run short
        stop = 1'b1;
        do_start(2, 3, 5, 'hA5, 0);
        stop = 1'b0;
        run_trace(0, -1, -1);
        build_exp(2, 3, 'hA5, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL gap_timeout: still busy after %0d cycles expected idle", BUDGET); end
        checks++; if (h_data.size() != 6) begin errors++; $display("FAIL gap_count: got %0d beats expected 6", h_data.size()); end
        for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
            checks++;
            if (h_data[k] !== e_data[k] || h_last[k] !== e_last[k]) begin
                errors++;
                $display("FAIL gap_beat%0d: got %h/%b expected %h/%b", k, h_data[k], h_last[k], e_data[k], e_last[k]);
            end
        end
        for (int k = 2; k < h_idx.size(); k += 2) begin
            checks++;
            if (h_idx[k] - h_idx[k-1] != 6) begin errors++; $display("FAIL gap_spacing%0d: got %0d idle cycles expected 5", k, h_idx[k] - h_idx[k-1] - 1); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL gap_done: got %0d pulses expected 1", n_done); end
        fs_exp += 32'd3;
    endtask

    task automatic test_stop();
        do_start(8, 0, 0, 'h33, 0);
        run_trace(0, 1, -1);
        build_exp(8, 1, 'h33, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL stop_timeout: still busy after %0d cycles expected idle", BUDGET); end
        checks++; if (h_data.size() != 8) begin errors++; $display("FAIL stop_count: got %0d beats expected 8", h_data.size()); end
        for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
            checks++;
            if (h_data[k] !== e_data[k] || h_last[k] !== e_last[k]) begin
                errors++;
                $display("FAIL stop_beat%0d: got %h/%b expected %h/%b", k, h_data[k], h_last[k], e_data[k], e_last[k]);
            end
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL stop_done: got %0d pulses expected 0", n_done); end
        fs_exp += 32'd1;
        checks++; if (frames_sent !== fs_exp) begin errors++; $display("FAIL stop_frames: got %0d expected %0d", frames_sent, fs_exp); end
    endtask

    task automatic test_stop_in_gap();
        do_start(2, 0, 10, 'h01, 0);
        run_trace(0, 3, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL gapstop_timeout: still busy after %0d cycles expected idle", BUDGET); end
        checks++; if (h_data.size() != 2 || fall_at != 4) begin errors++; $display("FAIL gapstop_exit: got %0d beats idle at %0d expected 2 beats idle at 4", h_data.size(), fall_at); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL gapstop_done: got %0d pulses expected 0", n_done); end
        fs_exp += 32'd1;
    endtask

    task automatic test_random();
        int len, cnt, gap, seed;
        for (int it = 0; it < 6; it++) begin
            len  = $urandom_range(0, 5);
            cnt  = $urandom_range(1, 3);
            gap  = $urandom_range(0, 3);
            seed = $urandom_range(0, 255);
            do_start(len, cnt, gap, seed, 0);
            run_trace(2, -1, 1);
            build_exp(len, cnt, seed, 0);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: still busy after %0d cycles expected idle", it, BUDGET); end
            checks++; if (h_data.size() != e_data.size()) begin errors++; $display("FAIL rand%0d_count: got %0d beats expected %0d", it, h_data.size(), e_data.size()); end
            for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
                checks++;
                if (h_data[k] !== e_data[k] || h_last[k] !== e_last[k] || h_user[k] !== e_user[k]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h/%b/%b expected %h/%b/%b", it, k, h_data[k], h_last[k], h_user[k], e_data[k], e_last[k], e_user[k]);
                end
            end
            checks++; if (idle_valid != gap * (cnt - 1)) begin errors++; $display("FAIL rand%0d_gaps: got %0d idle cycles expected %0d", it, idle_valid, gap * (cnt - 1)); end
            checks++; if (n_done != 1 || done_at != last_hs + 1) begin errors++; $display("FAIL rand%0d_done: got %0d pulses at %0d expected 1 at %0d", it, n_done, done_at, last_hs + 1); end
            fs_exp += 32'(cnt);
            checks++; if (frames_sent !== fs_exp) begin errors++; $display("FAIL rand%0d_frames: got %0d expected %0d", it, frames_sent, fs_exp); end
        end
    endtask

    task automatic test_reset_mid();
        int seed2;
        do_start(6, 0, 0, 'h77, 0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== '0) begin errors++; $display("FAIL rstmid_outputs: got tvalid %b busy %b tdata %h expected 0 0 0", tvalid, busy, tdata); end
        checks++; if (frames_sent !== 32'd0) begin errors++; $display("FAIL rstmid_frames: got %0d expected 0", frames_sent); end
        #1 rst = 1'b0;
        tick();
        fs_exp = 32'd0;
        seed2 = $urandom_range(0, 255);
        do_start(6, 1, 0, seed2, 0);
        run_trace(0, -1, -1);
        build_exp(6, 1, seed2, 0);
        checks++; if (h_data.size() != 6) begin errors++; $display("FAIL rstmid_count: got %0d beats expected 6", h_data.size()); end
        for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
            checks++;
            if (h_data[k] !== e_data[k] || h_last[k] !== e_last[k]) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got %h/%b expected %h/%b", k, h_data[k], h_last[k], e_data[k], e_last[k]);
            end
        end
        fs_exp += 32'd1;
        checks++; if (frames_sent !== fs_exp) begin errors++; $display("FAIL rstmid_frames_after: got %0d expected %0d", frames_sent, fs_exp); end
    endtask

`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
    task automatic test_bad_frame();
        int nbad;
        do_start(3, 4, 1, 'h20, 2);
        run_trace(2, -1, -1);
        build_exp(3, 4, 'h20, 2);
        checks++; if (h_data.size() != e_data.size()) begin errors++; $display("FAIL bad_count: got %0d beats expected %0d", h_data.size(), e_data.size()); end
        nbad = 0;
        for (int k = 0; k < h_data.size() && k < e_data.size(); k++) begin
            if (h_user[k]) nbad++;
            checks++;
            if (h_user[k] !== e_user[k] || h_data[k] !== e_data[k]) begin
                errors++;
                $display("FAIL bad_beat%0d: got %h/%b expected %h/%b", k, h_data[k], h_user[k], e_data[k], e_user[k]);
            end
        end
        checks++; if (nbad != 2) begin errors++; $display("FAIL bad_total: got %0d marked beats expected 2", nbad); end
        fs_exp += 32'd4;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_stop();
        test_stop_in_gap();
        test_random();
`ifdef AXIS_PATTERN_GEN_BAD_FRAME_EN
        test_bad_frame();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
